// File: rtl/parc_testmemresponder_pkg.sv
// Shared message definitions for the test memory responder: field widths,
// request type codes, len encodings and the packed response layout.
package parc_testmemresponder_pkg;

  localparam int unsigned c_data_sz = 32;
  localparam int unsigned c_len_sz  = 2;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef enum logic [c_len_sz-1:0] {
    LEN_WORD = 2'd0,
    LEN_BYTE = 2'd1,
    LEN_HALF = 2'd2,
    LEN_RSVD = 2'd3
  } mem_len_e;

  // Packed response {type, len, data}, MSB first.
  typedef struct packed {
    mem_type_e             msg_type;
    logic [c_len_sz-1:0]   len;
    logic [c_data_sz-1:0]  data;
  } mem_resp_t;

  // Little-endian sub-word extraction, zero-extended; reserved len reads 0.
  function automatic logic [c_data_sz-1:0] mem_read_extract(
    input logic [c_data_sz-1:0] word,
    input logic [1:0]           offset,
    input mem_len_e             len
  );
    logic [c_data_sz-1:0] result;
    result = '0;
    case (len)
      LEN_WORD: result = word;
      LEN_BYTE: result = {24'b0, word[{offset, 3'b000} +: 8]};
      LEN_HALF: result = {16'b0, word[{offset[1], 4'b0000} +: 16]};
      default:  result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/parc_testmemresponder_delay_pipe.sv
// Fixed-latency valid+payload shift register. Every stage clears on reset so
// in-flight responses are dropped and the output message reads zero.
module parc_testmemresponder_delay_pipe #(
  parameter int p_latency = 2,
  parameter int p_width   = 35
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  input  logic [p_width-1:0] in_payload,
  output logic               out_val,
  output logic [p_width-1:0] out_payload
);

  logic [p_latency-1:0] val_q;
  logic [p_width-1:0]   payload_q [p_latency];

  // Shift valid and payload one stage per cycle; idle slots carry a zero payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
      for (int i = 0; i < p_latency; i++) begin
        payload_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // old value, so loop order does not matter and this is a true shift.
      val_q[0]     <= in_val;
      payload_q[0] <= in_val ? in_payload : '0;
      for (int i = 1; i < p_latency; i++) begin
        val_q[i]     <= val_q[i-1];
        payload_q[i] <= payload_q[i-1];
      end
    end
  end

  assign out_val     = val_q[p_latency-1];
  assign out_payload = payload_q[p_latency-1];

endmodule

// File: rtl/parc_testmemresponder.sv
// Single-port test memory responder: accepts packed requests, reads or writes
// a word array with little-endian sub-word access, and returns a packed
// response after p_latency cycles. Optional periodic request back-pressure.
module parc_testmemresponder
  import parc_testmemresponder_pkg::*;
#(
  parameter int p_addr_sz      = 32,
  parameter int p_data_sz      = 32,
  parameter int p_mem_words    = 1024,
  parameter int p_latency      = 2,
  parameter int p_stall_period = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_addr_sz+p_data_sz+2:0] memreq_msg,
  input  logic                           memreq_val,
  output logic                           memreq_rdy,
  output logic [p_data_sz+2:0]           memresp_msg,
  output logic                           memresp_val
);

  localparam int c_idx_sz = $clog2(p_mem_words);
  localparam int c_cnt_sz = (p_stall_period > 1) ? $clog2(p_stall_period) : 1;
  localparam logic [c_cnt_sz-1:0] c_cnt_last =
    c_cnt_sz'((p_stall_period > 0) ? p_stall_period - 1 : 0);

  // Request fields, unpacked from {type, addr, len, data}.
  mem_type_e            req_type;
  logic [p_addr_sz-1:0] req_addr;
  mem_len_e             req_len;
  logic [p_data_sz-1:0] req_data;

  assign req_data = memreq_msg[p_data_sz-1:0];
  assign req_len  = mem_len_e'(memreq_msg[p_data_sz+1:p_data_sz]);
  assign req_addr = memreq_msg[p_data_sz+2 +: p_addr_sz];
  assign req_type = mem_type_e'(memreq_msg[p_data_sz+2+p_addr_sz]);

  // Upper address bits are ignored so addresses wrap modulo the array size.
  logic [c_idx_sz-1:0] idx;
  logic [1:0]          offset;
  logic                unused_addr_bits;

  assign idx              = req_addr[c_idx_sz+1:2];
  assign offset           = req_addr[1:0];
  assign unused_addr_bits = ^req_addr[p_addr_sz-1:c_idx_sz+2];

  logic fire;
  assign fire = memreq_val & memreq_rdy;

  // ---------------------------------------------------------------------------
  // Back-pressure: free-running counter, rdy dropped on its last count
  // ---------------------------------------------------------------------------
  logic [c_cnt_sz-1:0] stall_cnt;
  logic [c_cnt_sz-1:0] cnt_next;
  logic                rdy_next;

  // Next stall-counter value; wraps at p_stall_period-1.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch.
    cnt_next = '0;
    if (p_stall_period > 1) begin
      cnt_next = (stall_cnt == c_cnt_last) ? '0 : stall_cnt + c_cnt_sz'(1);
    end
  end

  assign rdy_next = (p_stall_period == 0) || (cnt_next != c_cnt_last);

  // Registered ready and stall counter; ready stays low while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      memreq_rdy <= 1'b0;
    end else begin
      stall_cnt  <= cnt_next;
      memreq_rdy <= rdy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Word array
  // ---------------------------------------------------------------------------
  logic [p_data_sz-1:0] mem [p_mem_words];

  // Byte-masked write at the accepting edge; reserved len writes nothing.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset: it behaves as RAM and the bench owns its
    // initial contents, so only the control state above is reset.
    if (fire && req_type == MEM_WRITE) begin
      case (req_len)
        LEN_WORD: mem[idx]                           <= req_data;
        LEN_BYTE: mem[idx][{offset, 3'b000} +: 8]    <= req_data[7:0];
        LEN_HALF: mem[idx][{offset[1], 4'b0000} +: 16] <= req_data[15:0];
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response formation and delay
  // ---------------------------------------------------------------------------
  mem_resp_t resp_d;

  // Response echoes type and len; reads return extracted data, writes zero.
  always_comb begin
    resp_d          = '0;
    resp_d.msg_type = req_type;
    resp_d.len      = req_len;
    if (req_type == MEM_READ) begin
      resp_d.data = mem_read_extract(mem[idx], offset, req_len);
    end
  end

  parc_testmemresponder_delay_pipe #(
    .p_latency (p_latency),
    .p_width   ($bits(mem_resp_t))
  ) u_delay_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_val      (fire),
    .in_payload  (resp_d),
    .out_val     (memresp_val),
    .out_payload (memresp_msg)
  );

endmodule

// File: doc/parc_testmemresponder.md
Name: parc_TestMemResponder

Overview:
- Single-port memory responder: the target end of the VC memory request/response protocol that the PARCv2 core initiates.
- Accepts packed request messages, performs the read or write on an internal word array, and returns a packed response after a fixed programmable latency.
- One instance serves imem and a second serves dmem in the core test harness.
- Contains an optional periodic back-pressure generator so the core's stall paths can be exercised.

Parameters:
- p_addr_sz, 32, request address width (bits).
- p_data_sz, 32, request and response data width (bits); fixed at 32.
- p_mem_words, 1024, depth of the word array (power of two).
- p_latency, 2, cycles from request acceptance to response valid; must be ≥1.
- p_stall_period, 0, when nonzero, memreq_rdy is deasserted for one cycle out of every p_stall_period cycles; 0 disables stalls.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- memreq_msg  in  `VC_MEM_REQ_MSG_SZ(32,32)  packed request {type, addr, len, data}.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  responder can accept a request this cycle.
- memresp_msg  out  `VC_MEM_RESP_MSG_SZ(32)  packed response {type, len, data}.
- memresp_val  out  1  response valid; held for exactly one cycle, with no backpressure.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values (async assertion clears these immediately):
  - memreq_rdy = 0, memresp_val = 0, memresp_msg = 0.
  - Delay pipeline valid bits = 0; stall counter = 0.
  - Memory contents are not reset; they are loaded by the testbench through hierarchical access.
- Acceptance (fire) = memreq_val & memreq_rdy at a rising edge.
- memreq_rdy is a registered output:
  - 1 on every cycle after reset deassertion, except the stall cycle.
  - Stall cycle: the stall counter counts 0..p_stall_period-1 and wraps; rdy = 0 when the counter equals p_stall_period-1.
  - The counter runs every cycle, independent of val.
- Addressing:
  - Word index = addr[log2(p_mem_words)+1 : 2].
  - Higher address bits are ignored, so addresses wrap modulo the memory size.
  - Byte offset = addr[1:0]. Little-endian.
- len encoding: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = reserved.
- Reads, performed at fire:
  - len 0: full word; addr[1:0] is ignored.
  - len 1: the selected byte, zero-extended.
  - len 2: the halfword at addr[1], zero-extended.
  - len 3: returns 0.
- Writes, performed at the fire edge:
  - len 0 writes the whole word.
  - len 1 writes only the addressed byte from data[7:0].
  - len 2 writes only the addressed halfword from data[15:0].
  - len 3 writes nothing.
  - Write response data = 0.
- Ordering: requests complete in order. A read accepted the cycle after a write to the same word observes the new value.
- Response contents: type = request type, len = request len, data as above.
- Latency: a request fired at edge N produces memresp_val = 1 during the cycle following edge N+p_latency-1. p_latency = 1 therefore means the response is visible the cycle after acceptance.
- Throughput: one response per cycle; back-to-back fires produce back-to-back responses.
- Delay pipeline: a shift register of p_latency stages, each holding {val, type, len, data}.
- No backpressure on responses: the consumer must always accept memresp_val.
- Reset mid-operation drops all in-flight requests. No response is produced for them after reset deassertion; writes that already fired remain in memory.

Decomposition:
- Message field widths, type codes (READ = 0, WRITE = 1) and len encodings are taken from the shared vc-MemReqMsg / vc-MemRespMsg definitions; no new constants are introduced.
- Reuse vc_MemReqMsgFromBits to unpack requests and vc_MemRespMsgToBits to pack responses.
- One natural sub-module: parc_TestMemDelayPipe, the parameterised p_latency-stage valid+payload shift register with async reset.

Test Plan:
- Word read, p_latency = 2: preload word[4] = 32'hDEADBEEF; read addr 0x10, len 0 at cycle 5 → memresp_val = 1 at cycle 7 only, data = 32'hDEADBEEF, type = 0.
- Sub-word write/read: write addr 0x21, len 1, data 0xAB over word[8] = 0x00000000 → word[8] = 0x0000AB00. Then read addr 0x22, len 2 → data = 0x00000000; read addr 0x21, len 1 → data = 0x000000AB.
- Back-to-back with RAW: write 0x12345678 to addr 0x40, then read addr 0x40 on the next cycle → two consecutive responses; write data = 0, read data = 0x12345678.
- Stall injection, p_stall_period = 4, memreq_val held high for 12 cycles → memreq_rdy low on exactly cycles 3, 7 and 11 after reset release; 9 requests fire; 9 responses in order.
- Wrap-around: p_mem_words = 1024; write 0xCAFEF00D to addr 0x1000 → word[0] = 0xCAFEF00D; read addr 0x0 returns it.
- Mid-flight reset: fire a read, assert reset one cycle later for 2 cycles → memresp_val and memreq_rdy go to 0 immediately and stay 0 through reset; no response appears afterward.
